vram_arbiter: RTL and testbench

Shares the single GPU VRAM port (20-bit address, 16-bit data, `vram_re`/`vram_we`/`vram_rdy`) among three GPU-internal requesters: display scanout, CPU/DMA VRAM transfer (GP0 image load/store), and the draw engine. Sits inside `gpu` between the requester blocks and the VRAM interface. Issues one access at a time, with fixed priority for scanout and round-robin between DMA and draw. Honors a draw-engine lock for atomic read-modify-write, and recovers from a missing `vram_rdy` via a timeout.

---
 rtl/gpu_pkg.sv | 18 +
 rtl/vram_arb_pick.sv | 35 +++
 rtl/vram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU types: VRAM requester identifiers, arbiter FSM states and VRAM bus widths.
package gpu_pkg;

  localparam int VRAM_AW = 20;
  localparam int VRAM_DW = 16;

  typedef enum logic [1:0] {
    REQ_SCAN = 2'd0,
    REQ_DMA  = 2'd1,
    REQ_DRAW = 2'd2
  } vram_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } vram_arb_state_t;

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational winner select: scanout first, then a locked draw engine, else dma/draw round-robin.
module vram_arb_pick
  import gpu_pkg::*;
(
  input  logic      i_scan_req,
  input  logic      i_dma_req,
  input  logic      i_draw_req,
  input  logic      i_lock_active,
  input  logic      i_rr_dma,
  output logic      o_valid,
  output vram_req_t o_winner
);

  logic w_dma_ok;

  // An active draw lock hides dma completely, even while draw is between accesses.
  assign w_dma_ok = i_dma_req & ~i_lock_active;
  assign o_valid  = i_scan_req | w_dma_ok | i_draw_req;

  always_comb begin
    o_winner = REQ_SCAN;
    if (i_scan_req) begin
      o_winner = REQ_SCAN;
    end else if (i_lock_active && i_draw_req) begin
      o_winner = REQ_DRAW;
    end else if (w_dma_ok && i_draw_req) begin
      o_winner = i_rr_dma ? REQ_DMA : REQ_DRAW;
    end else if (w_dma_ok) begin
      o_winner = REQ_DMA;
    end else if (i_draw_req) begin
      o_winner = REQ_DRAW;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for scanout, dma and draw: one access in flight, draw lock, rdy timeout.
module vram_arbiter
  import gpu_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int MAX_LOCK = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_req,
  input  logic               scan_we,
  input  logic [VRAM_AW-1:0] scan_addr,
  input  logic [VRAM_DW-1:0] scan_wdata,
  output logic               scan_gnt,
  output logic               scan_rvalid,
  output logic [VRAM_DW-1:0] scan_rdata,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [VRAM_AW-1:0] dma_addr,
  input  logic [VRAM_DW-1:0] dma_wdata,
  output logic               dma_gnt,
  output logic               dma_rvalid,
  output logic [VRAM_DW-1:0] dma_rdata,
  input  logic               draw_req,
  input  logic               draw_we,
  input  logic [VRAM_AW-1:0] draw_addr,
  input  logic [VRAM_DW-1:0] draw_wdata,
  output logic               draw_gnt,
  output logic               draw_rvalid,
  output logic [VRAM_DW-1:0] draw_rdata,
  input  logic               draw_lock,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_wdata,
  input  logic [VRAM_DW-1:0] vram_rdata,
  output logic               vram_re,
  output logic               vram_we,
  input  logic               vram_rdy,
  output logic               err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);

  vram_arb_state_t    r_state;
  vram_req_t          r_owner;
  logic               r_we;
  logic [VRAM_AW-1:0] r_addr;
  logic [VRAM_DW-1:0] r_wdata;
  logic [TW-1:0]      r_tcnt;
  logic               r_lock;
  logic [LW-1:0]      r_lock_cnt;
  logic               r_rr_dma;
  logic               r_err;

  logic               w_lock;
  logic               w_pick_valid;
  vram_req_t          w_winner;
  logic               w_issue;
  logic               w_sel_we;
  logic [VRAM_AW-1:0] w_sel_addr;
  logic [VRAM_DW-1:0] w_sel_wdata;
  logic               w_done_rdy;
  logic               w_done_to;
  logic               w_rvalid;
  logic [VRAM_DW-1:0] w_rdata;
  logic [LW-1:0]      w_lock_next;

  assign w_lock = r_lock & draw_lock;

  vram_arb_pick u_pick (
    .i_scan_req   (scan_req),
    .i_dma_req    (dma_req),
    .i_draw_req   (draw_req),
    .i_lock_active(w_lock),
    .i_rr_dma     (r_rr_dma),
    .o_valid      (w_pick_valid),
    .o_winner     (w_winner)
  );

  always_comb begin
    w_sel_we    = scan_we;
    w_sel_addr  = scan_addr;
    w_sel_wdata = scan_wdata;
    case (w_winner)
      REQ_DMA: begin
        w_sel_we    = dma_we;
        w_sel_addr  = dma_addr;
        w_sel_wdata = dma_wdata;
      end
      REQ_DRAW: begin
        w_sel_we    = draw_we;
        w_sel_addr  = draw_addr;
        w_sel_wdata = draw_wdata;
      end
      default: ;
    endcase
  end

  // Gating with rst keeps every combinational output at zero while reset is held.
  assign w_issue     = rst & (r_state == IDLE) & w_pick_valid;
  assign w_done_rdy  = rst & (r_state == WAIT) & vram_rdy;
  assign w_done_to   = rst & (r_state == WAIT) & ~vram_rdy & (r_tcnt == TW'(TIMEOUT - 1));
  assign w_rvalid    = (w_done_rdy | w_done_to) & ~r_we;
  assign w_rdata     = (w_done_rdy & ~r_we) ? vram_rdata : '0;
  assign w_lock_next = (r_lock ? r_lock_cnt : '0) + LW'(1);

  assign scan_gnt    = w_issue & (w_winner == REQ_SCAN);
  assign dma_gnt     = w_issue & (w_winner == REQ_DMA);
  assign draw_gnt    = w_issue & (w_winner == REQ_DRAW);
  assign scan_rvalid = w_rvalid & (r_owner == REQ_SCAN);
  assign dma_rvalid  = w_rvalid & (r_owner == REQ_DMA);
  assign draw_rvalid = w_rvalid & (r_owner == REQ_DRAW);
  assign scan_rdata  = w_rdata;
  assign dma_rdata   = w_rdata;
  assign draw_rdata  = w_rdata;

  assign vram_addr   = w_issue ? w_sel_addr : r_addr;
  assign vram_wdata  = w_issue ? w_sel_wdata : r_wdata;
  assign vram_re     = w_issue & ~w_sel_we;
  assign vram_we     = w_issue & w_sel_we;
  assign err_timeout = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_owner    <= REQ_SCAN;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tcnt     <= '0;
      r_lock     <= 1'b0;
      r_lock_cnt <= '0;
      r_rr_dma   <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      if (r_lock && !draw_lock) begin
        r_lock     <= 1'b0;
        r_lock_cnt <= '0;
      end
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_owner <= w_winner;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_tcnt  <= '0;
            r_state <= WAIT;
            if (w_winner == REQ_DMA) begin
              r_rr_dma <= 1'b0;
            end else if (w_winner == REQ_DRAW) begin
              r_rr_dma <= 1'b1;
              // The grant that reaches MAX_LOCK ends the lock so dma gets the next turn.
              if (draw_lock) begin
                if (w_lock_next >= LW'(MAX_LOCK)) begin
                  r_lock     <= 1'b0;
                  r_lock_cnt <= '0;
                end else begin
                  r_lock     <= 1'b1;
                  r_lock_cnt <= w_lock_next;
                end
              end
            end
          end
        end
        WAIT: begin
          if (vram_rdy) begin
            r_state <= IDLE;
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: read latency, contention order, draw lock, timeout and reset.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_req = 0, scan_we = 0, dma_req = 0, dma_we = 0, draw_req = 0, draw_we = 0;
  logic [19:0] scan_addr = 0, dma_addr = 0, draw_addr = 0;
  logic [15:0] scan_wdata = 0, dma_wdata = 0, draw_wdata = 0;
  logic        draw_lock = 0;
  logic [15:0] vram_rdata = 0;
  logic        vram_rdy = 0;
  logic        scan_gnt, scan_rvalid, dma_gnt, dma_rvalid, draw_gnt, draw_rvalid;
  logic [15:0] scan_rdata, dma_rdata, draw_rdata;
  logic [19:0] vram_addr;
  logic [15:0] vram_wdata;
  logic        vram_re, vram_we, err_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.TIMEOUT(64), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .scan_req(scan_req), .scan_we(scan_we), .scan_addr(scan_addr), .scan_wdata(scan_wdata),
    .scan_gnt(scan_gnt), .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_gnt(draw_gnt), .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata),
    .draw_lock(draw_lock),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .vram_re(vram_re), .vram_we(vram_we), .vram_rdy(vram_rdy),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every step starts on a falling edge with vram_rdy released by default.
  task automatic tick();
    @(negedge clk);
    vram_rdy = 1'b0;
  endtask

  logic [2:0] cont_exp [6];

  initial begin
    cont_exp = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b010, 3'b001};

    // Reset state
    tick(); #1;
    chk("rst_gnt", {29'd0, scan_gnt, dma_gnt, draw_gnt}, 32'd0);
    chk("rst_strobes", {30'd0, vram_re, vram_we}, 32'd0);
    chk("rst_addr", {12'd0, vram_addr}, 32'd0);
    chk("rst_wdata", {16'd0, vram_wdata}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    tick(); rst = 1'b1;

    // Single dma read, VRAM answers 3 cycles after grant
    tick(); dma_req = 1; dma_we = 0; dma_addr = 20'h00100; #1;
    chk("rd_gnt", {29'd0, scan_gnt, dma_gnt, draw_gnt}, 32'b010);
    chk("rd_re", {30'd0, vram_re, vram_we}, 32'b10);
    chk("rd_addr", {12'd0, vram_addr}, 32'h00100);
    tick(); dma_req = 0; #1;
    chk("rd_wait_re", {31'd0, vram_re}, 32'd0);
    chk("rd_hold_addr", {12'd0, vram_addr}, 32'h00100);
    tick(); #1;
    chk("rd_no_early_rv", {31'd0, dma_rvalid}, 32'd0);
    tick(); vram_rdy = 1; vram_rdata = 16'hBEEF; #1;
    chk("rd_rvalid", {29'd0, scan_rvalid, dma_rvalid, draw_rvalid}, 32'b010);
    chk("rd_rdata", {16'd0, dma_rdata}, 32'h0000BEEF);

    // Draw read with no vram_rdy: timeout on cycle 64 after the grant
    tick(); draw_req = 1; draw_we = 0; draw_addr = 20'h00300; #1;
    chk("to_gnt", {31'd0, draw_gnt}, 32'd1);
    for (int i = 1; i < 64; i++) begin
      tick();
      if (i == 1) draw_req = 0;
    end
    #1;
    chk("to_no_early_rv", {31'd0, draw_rvalid}, 32'd0);
    tick(); vram_rdata = 16'hFFFF; #1;
    chk("to_rvalid", {31'd0, draw_rvalid}, 32'd1);
    chk("to_rdata_zero", {16'd0, draw_rdata}, 32'd0);
    chk("to_err_not_yet", {31'd0, err_timeout}, 32'd0);
    tick(); draw_req = 1; draw_we = 1; draw_addr = 20'h00404; draw_wdata = 16'h1234; #1;
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    chk("to_next_gnt", {31'd0, draw_gnt}, 32'd1);
    chk("to_next_we", {30'd0, vram_re, vram_we}, 32'b01);
    chk("to_next_wdata", {16'd0, vram_wdata}, 32'h1234);
    tick(); draw_req = 0; vram_rdy = 1; #1;
    chk("wr_no_rvalid", {29'd0, scan_rvalid, dma_rvalid, draw_rvalid}, 32'd0);

    // Contention: scan wins while requesting, then dma/draw alternate
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        scan_req = 1; dma_req = 1; draw_req = 1; scan_we = 0; dma_we = 0; draw_we = 0;
      end
      if (k == 2) scan_req = 0;
      #1;
      chk($sformatf("cont_gnt%0d", k), {29'd0, scan_gnt, dma_gnt, draw_gnt}, {29'd0, cont_exp[k]});
      tick(); vram_rdy = 1; vram_rdata = 16'hA000 + 16'(k); #1;
      chk($sformatf("cont_rv%0d", k), {29'd0, scan_rvalid, dma_rvalid, draw_rvalid}, {29'd0, cont_exp[k]});
      chk($sformatf("cont_rd%0d", k), {16'd0, scan_rdata}, 32'hA000 + 32'(k));
    end
    tick(); scan_req = 0; dma_req = 0; draw_req = 0; vram_rdy = 1; #1;
    chk("idle_rdy_ignored", {29'd0, scan_rvalid, dma_rvalid, draw_rvalid}, 32'd0);

    // Lock: draw read then write at 0x200 precede a pending dma request
    tick(); draw_req = 1; draw_lock = 1; draw_we = 0; draw_addr = 20'h00200; #1;
    chk("lk_gnt1", {29'd0, scan_gnt, dma_gnt, draw_gnt}, 32'b001);
    tick(); dma_req = 1; dma_we = 1; dma_addr = 20'h00500; draw_we = 1; draw_wdata = 16'h5555;
    vram_rdy = 1; vram_rdata = 16'h0F0F; #1;
    chk("lk_rv1", {16'd0, draw_rdata}, 32'h0F0F);
    tick(); #1;
    chk("lk_gnt2", {29'd0, scan_gnt, dma_gnt, draw_gnt}, 32'b001);
    chk("lk_addr2", {12'd0, vram_addr}, 32'h00200);
    chk("lk_we2", {30'd0, vram_re, vram_we}, 32'b01);
    tick(); draw_req = 0; draw_lock = 0; vram_rdy = 1;
    tick(); #1;
    chk("lk_dma_after", {29'd0, scan_gnt, dma_gnt, draw_gnt}, 32'b010);
    tick(); dma_req = 0; vram_rdy = 1;

    // Lock held for 10 draw requests: dma gets in after the 8th draw grant
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin
        draw_req = 1; draw_lock = 1; draw_we = 1; dma_req = 1;
      end
      #1;
      chk($sformatf("max_gnt%0d", k), {29'd0, scan_gnt, dma_gnt, draw_gnt},
          (k == 8) ? 32'b010 : 32'b001);
      tick(); vram_rdy = 1;
    end
    tick(); draw_req = 0; dma_req = 0; draw_lock = 0;

    // Reset while an access is outstanding
    tick(); dma_req = 1; dma_we = 0; dma_addr = 20'h00600; #1;
    chk("rs_gnt", {31'd0, dma_gnt}, 32'd1);
    chk("rs_err_before", {31'd0, err_timeout}, 32'd1);
    tick(); dma_req = 0; #1;
    rst = 0; vram_rdy = 1; vram_rdata = 16'h9999; #1;
    chk("rs_no_rvalid", {29'd0, scan_rvalid, dma_rvalid, draw_rvalid}, 32'd0);
    chk("rs_addr", {12'd0, vram_addr}, 32'd0);
    chk("rs_rdata", {16'd0, dma_rdata}, 32'd0);
    chk("rs_err", {31'd0, err_timeout}, 32'd0);
    tick(); rst = 1; #1;
    chk("rs_idle_addr", {12'd0, vram_addr}, 32'd0);
    tick(); dma_req = 1; draw_req = 1; dma_we = 0; draw_we = 0; dma_addr = 20'h00700; #1;
    chk("rs_tie_dma", {29'd0, scan_gnt, dma_gnt, draw_gnt}, 32'b010);
    tick(); dma_req = 0; draw_req = 0; vram_rdy = 1; vram_rdata = 16'h7777; #1;
    chk("rs_rvalid", {29'd0, scan_rvalid, dma_rvalid, draw_rvalid}, 32'b010);
    chk("rs_rdata2", {16'd0, dma_rdata}, 32'h7777);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
